// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP multiplier constants, defaults and exception-flag layout
package fpu_pkg;

  localparam int EW_DEF = 8;
  localparam int SW_DEF = 23;
  localparam int BIAS   = (1 << (EW_DEF - 1)) - 1;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fpu_flags_t;

endpackage

// File: rtl/rne_round.sv
// rtl/rne_round.sv - combinational round-to-nearest-even of a stored fraction
module rne_round #(
  parameter int SW = 23
) (
  input  logic [SW-1:0] i_frac,
  input  logic          i_g,
  input  logic          i_st,
  output logic [SW-1:0] o_frac,
  output logic          o_carry,
  output logic          o_inexact
);

  logic          w_inc;
  logic [SW:0]   w_sum;

  // Round up when above half, or exactly half with an odd LSB; a carry out
  // leaves the low bits at zero, which is the renormalised fraction.
  assign w_inc     = i_g & (i_st | i_frac[0]);
  assign w_sum     = {1'b0, i_frac} + {{SW{1'b0}}, w_inc};
  assign o_frac    = w_sum[SW-1:0];
  assign o_carry   = w_sum[SW];
  assign o_inexact = i_g | i_st;

endmodule

// File: rtl/fpu_mult_norm_round.sv
// rtl/fpu_mult_norm_round.sv - FP multiply normalise/round/pack, elastic 2-stage pipeline
module fpu_mult_norm_round
  import fpu_pkg::*;
#(
  parameter int EW = EW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic signed [EW+1:0]     in_exp,
  input  logic [2*(SW+1)-1:0]      in_prod,
  input  logic                     in_zero,
  input  logic                     in_inf,
  input  logic                     in_nan,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EW+SW:0]           out_result,
  output logic                     out_overflow,
  output logic                     out_underflow,
  output logic                     out_invalid,
  output logic                     out_inexact
);

  localparam int W  = EW + SW + 1;
  localparam int PW = 2 * (SW + 1);
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);
  localparam logic [W-1:0] W_QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};

  // handshake
  logic w_s1_adv;
  logic w_s2_adv;

  // stage 1 (normalised) registers
  logic                 r1_valid;
  logic                 r1_sign;
  logic signed [XW-1:0] r1_exp;
  logic [SW-1:0]        r1_frac;
  logic                 r1_g;
  logic                 r1_st;
  logic                 r1_zero;
  logic                 r1_inf;
  logic                 r1_nan;

  // stage 2 (output) registers
  logic                 r_out_valid;
  logic [W-1:0]         r_result;
  fpu_flags_t           r_flags;

  // normalisation wires
  logic                 w_pov;
  logic [SW-1:0]        w1_frac;
  logic                 w1_g;
  logic                 w1_st;
  logic signed [XW-1:0] w1_exp;

  // rounding / pack wires
  logic [SW-1:0]        w_frac_r;
  logic                 w_carry;
  logic                 w_rnd_inexact;
  logic signed [XW-1:0] w_exp_r;
  logic                 w_ovf_hit;
  logic                 w_unf_hit;
  logic [W-1:0]         w_result;
  fpu_flags_t           w_flags;

  assign w_s2_adv = !r_out_valid | out_ready;
  assign w_s1_adv = !r1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  // Product has two integer bits; shift by one when the overflow bit is set.
  assign w_pov   = in_prod[PW-1];
  assign w1_frac = w_pov ? in_prod[PW-2:SW+1] : in_prod[PW-3:SW];
  assign w1_g    = w_pov ? in_prod[SW] : in_prod[SW-1];
  assign w1_st   = w_pov ? |in_prod[SW-1:0] : |in_prod[SW-2:0];
  assign w1_exp  = in_exp + $signed({{(XW-1){1'b0}}, w_pov});

  rne_round #(.SW(SW)) u_rne (
    .i_frac   (r1_frac),
    .i_g      (r1_g),
    .i_st     (r1_st),
    .o_frac   (w_frac_r),
    .o_carry  (w_carry),
    .o_inexact(w_rnd_inexact)
  );

  assign w_exp_r   = r1_exp + $signed({{(XW-1){1'b0}}, w_carry});
  assign w_ovf_hit = (w_exp_r >= EMAX);
  assign w_unf_hit = r1_exp[XW-1] | (r1_exp == '0);

  // Special-case / range priority mux producing the packed word and flags.
  always_comb begin
    w_result         = {r1_sign, w_exp_r[EW-1:0], w_frac_r};
    w_flags          = '0;
    w_flags.inexact  = w_rnd_inexact;
    if (r1_nan) begin
      w_result        = W_QNAN;
      w_flags         = '0;
      w_flags.invalid = 1'b1;
    end else if (r1_inf) begin
      w_result = {r1_sign, {EW{1'b1}}, {SW{1'b0}}};
      w_flags  = '0;
    end else if (r1_zero) begin
      w_result = {r1_sign, {(W-1){1'b0}}};
      w_flags  = '0;
    end else if (w_ovf_hit) begin
      w_result         = {r1_sign, {EW{1'b1}}, {SW{1'b0}}};
      w_flags          = '0;
      w_flags.overflow = 1'b1;
      w_flags.inexact  = 1'b1;
    end else if (w_unf_hit) begin
      w_result          = {r1_sign, {(W-1){1'b0}}};
      w_flags           = '0;
      w_flags.underflow = 1'b1;
      w_flags.inexact   = 1'b1;
    end
  end

  // Stage 1: capture the normalised operand set when the slot frees up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_exp   <= '0;
      r1_frac  <= '0;
      r1_g     <= 1'b0;
      r1_st    <= 1'b0;
      r1_zero  <= 1'b0;
      r1_inf   <= 1'b0;
      r1_nan   <= 1'b0;
    end else if (w_s1_adv) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign <= in_sign;
        r1_exp  <= w1_exp;
        r1_frac <= w1_frac;
        r1_g    <= w1_g;
        r1_st   <= w1_st;
        r1_zero <= in_zero;
        r1_inf  <= in_inf;
        r1_nan  <= in_nan;
      end
    end
  end

  // Stage 2: register the packed result; held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r1_valid;
      if (r1_valid) begin
        r_result <= w_result;
        r_flags  <= w_flags;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_result    = r_result;
  assign out_overflow  = r_flags.overflow;
  assign out_underflow = r_flags.underflow;
  assign out_invalid   = r_flags.invalid;
  assign out_inexact   = r_flags.inexact;

endmodule

// File: tb/tb_fpu_mult_norm_round.sv
// tb/tb_fpu_mult_norm_round.sv - directed self-checking bench for fpu_mult_norm_round
module tb_fpu_mult_norm_round;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic signed [9:0]  in_exp;
  logic [47:0]        in_prod;
  logic               in_zero;
  logic               in_inf;
  logic               in_nan;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic               out_overflow;
  logic               out_underflow;
  logic               out_invalid;
  logic               out_inexact;
  logic [3:0]         obs_flags;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected flags packed as {overflow, underflow, invalid, inexact}
  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [47:0] p;
    logic        z;
    logic        i;
    logic        n;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  assign obs_flags = {out_overflow, out_underflow, out_invalid, out_inexact};

  always #5 clk = ~clk;

  fpu_mult_norm_round #(.EW(8), .SW(23)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_prod      (in_prod),
    .in_zero      (in_zero),
    .in_inf       (in_inf),
    .in_nan       (in_nan),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_invalid  (out_invalid),
    .out_inexact  (out_inexact)
  );

  function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [47:0] p,
                              input logic z, input logic i, input logic n,
                              input logic [31:0] r, input logic [3:0] f);
    vec_t v;
    v.s = s; v.e = e; v.p = p; v.z = z; v.i = i; v.n = n; v.r = r; v.f = f;
    return v;
  endfunction

  task automatic set_in(input vec_t v);
    in_sign = v.s;
    in_exp  = v.e;
    in_prod = v.p;
    in_zero = v.z;
    in_inf  = v.i;
    in_nan  = v.n;
  endtask

  // Present one vector with out_ready=1; return at the negedge where its result should be shown.
  task automatic drive_one(input vec_t v, output logic early);
    set_in(v);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); early = out_valid;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 00000000", out_result); end
    n_cmp++; if (obs_flags !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", obs_flags); end
  endtask

  task automatic test_basic;
    logic early;
    drive_one(mk(1'b0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h0, 4'h0), early);
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early got %b want 0", early); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 32'h4010_0000) begin n_fail++; $display("FAIL basic_result got %h want 40100000", out_result); end
    n_cmp++; if (obs_flags !== 4'b0000) begin n_fail++; $display("FAIL basic_flags got %b want 0000", obs_flags); end
  endtask

  task automatic test_round;
    vec_t v[5];
    logic early;
    v[0] = mk(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 32'h3F80_0002, 4'b0001);
    v[1] = mk(0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 32'h3F80_0000, 4'b0001);
    v[2] = mk(0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'h4000_0000, 4'b0001);
    v[3] = mk(0, 10'd127, 48'h4000_0020_0000, 0, 0, 0, 32'h3F80_0000, 4'b0001);
    v[4] = mk(0, 10'd127, 48'h4000_0060_0000, 0, 0, 0, 32'h3F80_0001, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      drive_one(v[k], early);
      n_cmp++; if (out_result !== v[k].r) begin n_fail++; $display("FAIL round[%0d]_result got %h want %h", k, out_result, v[k].r); end
      n_cmp++; if (obs_flags !== v[k].f) begin n_fail++; $display("FAIL round[%0d]_flags got %b want %b", k, obs_flags, v[k].f); end
    end
  endtask

  task automatic test_range;
    vec_t v[8];
    logic early;
    v[0] = mk(0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'h7F80_0000, 4'b1001);
    v[1] = mk(1, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'hFF80_0000, 4'b1001);
    v[2] = mk(0, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 32'h0000_0000, 4'b0101);
    v[3] = mk(1, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 32'h8000_0000, 4'b0101);
    v[4] = mk(0, 10'd254, 48'h4000_0000_0000, 0, 0, 0, 32'h7F00_0000, 4'b0000);
    v[5] = mk(0, 10'd1,   48'h4000_0000_0000, 0, 0, 0, 32'h0080_0000, 4'b0000);
    v[6] = mk(0, 10'h3FB, 48'h4000_0000_0000, 0, 0, 0, 32'h0000_0000, 4'b0101);
    v[7] = mk(0, 10'd254, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'h7F80_0000, 4'b1001);
    for (int k = 0; k < 8; k++) begin
      drive_one(v[k], early);
      n_cmp++; if (out_result !== v[k].r) begin n_fail++; $display("FAIL range[%0d]_result got %h want %h", k, out_result, v[k].r); end
      n_cmp++; if (obs_flags !== v[k].f) begin n_fail++; $display("FAIL range[%0d]_flags got %b want %b", k, obs_flags, v[k].f); end
    end
  endtask

  task automatic test_specials;
    vec_t v[5];
    logic early;
    v[0] = mk(0, 10'd0,   48'h0,              0, 0, 1, 32'h7FC0_0000, 4'b0010);
    v[1] = mk(1, 10'd127, 48'h4000_0000_0000, 0, 1, 0, 32'hFF80_0000, 4'b0000);
    v[2] = mk(1, 10'd0,   48'h0,              1, 0, 0, 32'h8000_0000, 4'b0000);
    v[3] = mk(1, 10'd127, 48'h4000_0000_0000, 0, 1, 1, 32'h7FC0_0000, 4'b0010);
    v[4] = mk(1, 10'd254, 48'h8000_0000_0000, 1, 0, 0, 32'h8000_0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      drive_one(v[k], early);
      n_cmp++; if (out_result !== v[k].r) begin n_fail++; $display("FAIL special[%0d]_result got %h want %h", k, out_result, v[k].r); end
      n_cmp++; if (obs_flags !== v[k].f) begin n_fail++; $display("FAIL special[%0d]_flags got %b want %b", k, obs_flags, v[k].f); end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[3];
    v[0] = mk(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h4010_0000, 4'b0000);
    v[1] = mk(1, 10'd127, 48'h4000_0000_0000, 0, 0, 0, 32'hBF80_0000, 4'b0000);
    v[2] = mk(0, 10'd128, 48'h4000_0000_0000, 0, 0, 0, 32'h4000_0000, 4'b0000);
    @(posedge clk); #1;
    set_in(v[0]); in_valid = 1'b1;
    @(posedge clk); #1 set_in(v[1]);
    @(posedge clk); #1 set_in(v[2]);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_result !== v[k].r) begin n_fail++; $display("FAIL b2b[%0d] got v=%b %h want v=1 %h", k, out_valid, out_result, v[k].r); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    vec_t v[3];
    v[0] = mk(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h4010_0000, 4'b0000);
    v[1] = mk(0, 10'd127, 48'h4000_0000_0000, 0, 0, 0, 32'h3F80_0000, 4'b0000);
    v[2] = mk(0, 10'd128, 48'h4000_0000_0000, 0, 0, 0, 32'h4000_0000, 4'b0000);
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_in(v[0]); in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_a got %b want 1", in_ready); end
    @(posedge clk); #1 set_in(v[1]);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_b got %b want 1", in_ready); end
    @(posedge clk); #1 set_in(v[2]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready[%0d] got %b want 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_result !== v[0].r) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b %h want v=1 %h", k, out_valid, out_result, v[0].r); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_result !== v[k].r) begin n_fail++; $display("FAIL bp_order[%0d] got v=%b %h want v=1 %h", k, out_valid, out_result, v[k].r); end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_in(mk(0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'h0, 4'h0)); in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(mk(0, 10'd127, 48'h4000_0000_0000, 0, 0, 0, 32'h0, 4'h0));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h7F80_0000 || obs_flags !== 4'b1001) begin n_fail++; $display("FAIL rstmid_pre got v=%b %h %b want v=1 7f800000 1001", out_valid, out_result, obs_flags); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    n_cmp++; if (out_result !== 32'h0 || obs_flags !== 4'b0) begin n_fail++; $display("FAIL rstmid_data got %h %b want 00000000 0000", out_result, obs_flags); end
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard got %b want 0", out_valid); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_in(mk(0, 10'd0, 48'h0, 0, 0, 0, 32'h0, 4'h0));
    @(posedge clk); @(negedge clk);
    test_reset;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    test_basic;
    test_round;
    test_range;
    test_specials;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
